// File: rtl/oddr71_tx_gearbox.sv
// oddr71_tx_gearbox: 8:7 byte-to-word gearbox for the 7:1 serializer.
// Optional stats counters: define ODDR71_TX_GEARBOX_STATS_EN.
module oddr71_tx_gearbox #(
  parameter logic [6:0] IDLE_WORD = 7'h00,
  parameter bit         MSB_FIRST = 1'b0
) (
  input  logic        SCLK,
  input  logic        RSTN,
  input  logic [7:0]  IN_DATA,
  input  logic        IN_VALID,
  output logic        IN_READY,
  input  logic        FLUSH,
  output logic [6:0]  OUT_WORD,
  output logic        OUT_VALID,
`ifdef ODDR71_TX_GEARBOX_STATS_EN
  output logic [15:0] UNDERRUN_CNT,
  output logic [15:0] WORD_CNT,
`endif
  output logic        UNDERRUN
);

  logic [14:0] bit_q, bit_ae, bit_d;
  logic [3:0]  cnt_q, cnt_ae, cnt_d;
  logic [7:0]  byte_in;
  logic [6:0]  word_d;
  logic [6:0]  pad_mask;
  logic        emit, pad, acc;
  logic        uflag;
  logic        started_q, started_d;

  // wire order of the incoming byte
  always_comb begin
    byte_in = IN_DATA;
    if (MSB_FIRST) begin
      for (int i = 0; i < 8; i++)
        byte_in[i] = IN_DATA[7-i];
    end
  end

  assign emit     = (cnt_q >= 4'd7);
  assign pad      = FLUSH && (cnt_q != 4'd0)
                    && (cnt_q < 4'd7);
  assign pad_mask = ~(7'h7F << cnt_q[2:0]);

  // word selection and buffer state after the emit/pad step
  always_comb begin
    word_d = IDLE_WORD;
    bit_ae = bit_q;
    cnt_ae = cnt_q;
    unique case (1'b1)
      emit: begin
        word_d = bit_q[6:0];
        bit_ae = bit_q >> 7;
        cnt_ae = cnt_q - 4'd7;
      end
      pad: begin
        word_d = bit_q[6:0] & pad_mask;
        bit_ae = '0;
        cnt_ae = 4'd0;
      end
      default: ;
    endcase
  end

  assign IN_READY = ~FLUSH && (cnt_ae <= 4'd7);
  assign acc      = IN_VALID && IN_READY;

  // append the accepted byte above the surviving bits
  always_comb begin
    bit_d     = bit_ae;
    cnt_d     = cnt_ae;
    started_d = started_q;
    if (pad)
      started_d = 1'b0;
    if (acc) begin
      bit_d     = bit_ae
                  | ({7'b0, byte_in} << cnt_ae);
      cnt_d     = cnt_ae + 4'd8;
      started_d = 1'b1;
    end
  end

  assign uflag = started_q && !emit
                 && !pad && !FLUSH;

  // buffer, output word and sticky underrun registers
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      bit_q     <= '0;
      cnt_q     <= '0;
      OUT_WORD  <= IDLE_WORD;
      OUT_VALID <= 1'b0;
      UNDERRUN  <= 1'b0;
      started_q <= 1'b0;
    end else begin
      bit_q     <= bit_d;
      cnt_q     <= cnt_d;
      OUT_WORD  <= word_d;
      OUT_VALID <= emit || pad;
      started_q <= started_d;
      if (uflag)
        UNDERRUN <= 1'b1;
    end
  end

`ifdef ODDR71_TX_GEARBOX_STATS_EN
  // saturating underrun count, wrapping data word count
  always_ff @(posedge SCLK or negedge RSTN) begin
    if (!RSTN) begin
      UNDERRUN_CNT <= '0;
      WORD_CNT     <= '0;
    end else begin
      if (uflag && (UNDERRUN_CNT != 16'hFFFF))
        UNDERRUN_CNT <= UNDERRUN_CNT + 16'd1;
      if (emit || pad)
        WORD_CNT <= WORD_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_oddr71_tx_gearbox.sv
// tb_oddr71_tx_gearbox: directed bench for the 8:7 tx gearbox.
// Stats checks compile in with ODDR71_TX_GEARBOX_STATS_EN.
module tb_oddr71_tx_gearbox;

  localparam logic [6:0] IDLE = 7'h2A;

  logic       SCLK = 1'b0;
  logic       RSTN = 1'b0;
  logic [7:0] IN_DATA = 8'h00;
  logic       IN_VALID = 1'b0;
  logic       IN_READY;
  logic       FLUSH = 1'b0;
  logic [6:0] OUT_WORD;
  logic       OUT_VALID;
  logic       UNDERRUN;
`ifdef ODDR71_TX_GEARBOX_STATS_EN
  logic [15:0] UNDERRUN_CNT;
  logic [15:0] WORD_CNT;
`endif

  int checks = 0;
  int failures = 0;

  oddr71_tx_gearbox #(
    .IDLE_WORD(IDLE),
    .MSB_FIRST(1'b0)
  ) dut (
    .SCLK(SCLK),
    .RSTN(RSTN),
    .IN_DATA(IN_DATA),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .FLUSH(FLUSH),
    .OUT_WORD(OUT_WORD),
    .OUT_VALID(OUT_VALID),
`ifdef ODDR71_TX_GEARBOX_STATS_EN
    .UNDERRUN_CNT(UNDERRUN_CNT),
    .WORD_CNT(WORD_CNT),
`endif
    .UNDERRUN(UNDERRUN)
  );

  always #5 SCLK = ~SCLK;

  task automatic tick();
    @(posedge SCLK);
    #1;
  endtask

  task automatic do_reset();
    IN_VALID = 1'b0;
    FLUSH    = 1'b0;
    IN_DATA  = 8'h00;
    RSTN     = 1'b0;
    #3;
    @(negedge SCLK);
    RSTN = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (OUT_VALID !== 1'b0 || OUT_WORD !== IDLE) begin
      failures++;
      $display("FAIL reset_out: valid=%b word=%h want 0 %h",
               OUT_VALID, OUT_WORD, IDLE);
    end
    checks++;
    if (IN_READY !== 1'b1 || UNDERRUN !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: rdy=%b und=%b want 1 0",
               IN_READY, UNDERRUN);
    end
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (OUT_VALID !== 1'b0 || OUT_WORD !== IDLE ||
          IN_READY !== 1'b1 || UNDERRUN !== 1'b0) begin
        failures++;
        $display("FAIL idle_%0d: v=%b w=%h r=%b u=%b want 0 %h 1 0",
                 c, OUT_VALID, OUT_WORD, IN_READY, UNDERRUN, IDLE);
      end
    end
  endtask

  task automatic test_stream();
    logic [6:0] exp_w [8];
    exp_w = '{7'h00, 7'h02, 7'h08, 7'h18,
              7'h40, 7'h20, 7'h01, 7'h03};
    do_reset();
    for (int e = 1; e <= 10; e++) begin
      IN_VALID = (e <= 7);
      IN_DATA  = 8'(e - 1);
      tick();
      checks++;
      if (e == 1 || e == 10) begin
        if (OUT_VALID !== 1'b0 || OUT_WORD !== IDLE) begin
          failures++;
          $display("FAIL stream_idle_e%0d: v=%b w=%h want 0 %h",
                   e, OUT_VALID, OUT_WORD, IDLE);
        end
      end else begin
        if (OUT_VALID !== 1'b1 || OUT_WORD !== exp_w[e-2]) begin
          failures++;
          $display("FAIL stream_w%0d: v=%b w=%h want 1 %h",
                   e - 2, OUT_VALID, OUT_WORD, exp_w[e-2]);
        end
      end
    end
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL stream_empty: v=%b want 0", OUT_VALID);
    end
  endtask

  task automatic test_flush();
    do_reset();
    IN_DATA  = 8'hFF;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    FLUSH    = 1'b1;
    #1;
    checks++;
    if (IN_READY !== 1'b0) begin
      failures++;
      $display("FAIL flush_ready: rdy=%b want 0", IN_READY);
    end
    tick();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_WORD !== 7'h7F) begin
      failures++;
      $display("FAIL flush_w0: v=%b w=%h want 1 7f",
               OUT_VALID, OUT_WORD);
    end
    tick();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_WORD !== 7'h01) begin
      failures++;
      $display("FAIL flush_pad: v=%b w=%h want 1 01",
               OUT_VALID, OUT_WORD);
    end
    tick();
    checks++;
    if (OUT_VALID !== 1'b0 || OUT_WORD !== IDLE ||
        UNDERRUN !== 1'b0 || IN_READY !== 1'b0) begin
      failures++;
      $display("FAIL flush_idle: v=%b w=%h u=%b r=%b want 0 %h 0 0",
               OUT_VALID, OUT_WORD, UNDERRUN, IN_READY, IDLE);
    end
    FLUSH = 1'b0;
    tick();
    tick();
    checks++;
    if (UNDERRUN !== 1'b0 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL flush_after: u=%b v=%b want 0 0",
               UNDERRUN, OUT_VALID);
    end
  endtask

  task automatic test_back_to_back();
    int acc_n = 0;
    int stall_bad = 0;
    int ov_bad = 0;
    do_reset();
    IN_DATA  = 8'h3C;
    IN_VALID = 1'b1;
    tick();
    for (int w = 0; w < 64; w++) begin
      if (IN_READY === 1'b1)
        acc_n++;
      if (IN_READY !== ((w % 8) != 7))
        stall_bad++;
      IN_DATA = 8'(w);
      tick();
      if (OUT_VALID !== 1'b1)
        ov_bad++;
    end
    IN_VALID = 1'b0;
    checks++;
    if (acc_n != 56) begin
      failures++;
      $display("FAIL b2b_accepted: got %0d want 56", acc_n);
    end
    checks++;
    if (stall_bad != 0) begin
      failures++;
      $display("FAIL b2b_ready_pattern: bad=%0d want 0",
               stall_bad);
    end
    checks++;
    if (ov_bad != 0) begin
      failures++;
      $display("FAIL b2b_out_valid: bad=%0d want 0", ov_bad);
    end
  endtask

  task automatic test_underrun();
    do_reset();
    IN_VALID = 1'b1;
    IN_DATA  = 8'hA5;
    tick();
    IN_DATA  = 8'hC3;
    tick();
    IN_VALID = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_WORD !== 7'h25) begin
      failures++;
      $display("FAIL und_w0: v=%b w=%h want 1 25",
               OUT_VALID, OUT_WORD);
    end
    tick();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_WORD !== 7'h07 ||
        UNDERRUN !== 1'b0) begin
      failures++;
      $display("FAIL und_w1: v=%b w=%h u=%b want 1 07 0",
               OUT_VALID, OUT_WORD, UNDERRUN);
    end
    tick();
    checks++;
    if (OUT_VALID !== 1'b0 || UNDERRUN !== 1'b1) begin
      failures++;
      $display("FAIL und_set: v=%b u=%b want 0 1",
               OUT_VALID, UNDERRUN);
    end
`ifdef ODDR71_TX_GEARBOX_STATS_EN
    checks++;
    if (UNDERRUN_CNT !== 16'd1) begin
      failures++;
      $display("FAIL und_cnt1: got %0d want 1", UNDERRUN_CNT);
    end
`endif
    tick();
    tick();
    checks++;
    if (UNDERRUN !== 1'b1 || OUT_VALID !== 1'b0 ||
        IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL und_hold: u=%b v=%b r=%b want 1 0 1",
               UNDERRUN, OUT_VALID, IN_READY);
    end
`ifdef ODDR71_TX_GEARBOX_STATS_EN
    checks++;
    if (UNDERRUN_CNT !== 16'd3) begin
      failures++;
      $display("FAIL und_cnt3: got %0d want 3", UNDERRUN_CNT);
    end
`endif
    FLUSH = 1'b1;
    tick();
    FLUSH = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_WORD !== 7'h03) begin
      failures++;
      $display("FAIL und_pad: v=%b w=%h want 1 03",
               OUT_VALID, OUT_WORD);
    end
`ifdef ODDR71_TX_GEARBOX_STATS_EN
    checks++;
    if (WORD_CNT !== 16'd3) begin
      failures++;
      $display("FAIL word_cnt: got %0d want 3", WORD_CNT);
    end
`endif
    tick();
    checks++;
    if (UNDERRUN !== 1'b1 || OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL und_sticky: u=%b v=%b want 1 0",
               UNDERRUN, OUT_VALID);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    IN_DATA  = 8'hFF;
    IN_VALID = 1'b1;
    tick();
    tick();
    tick();
    IN_VALID = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_WORD !== 7'h7F) begin
      failures++;
      $display("FAIL mid_pre: v=%b w=%h want 1 7f",
               OUT_VALID, OUT_WORD);
    end
    #2;
    RSTN = 1'b0;
    #1;
    checks++;
    if (OUT_VALID !== 1'b0 || OUT_WORD !== IDLE ||
        UNDERRUN !== 1'b0 || IN_READY !== 1'b1) begin
      failures++;
      $display("FAIL mid_async: v=%b w=%h u=%b r=%b want 0 %h 0 1",
               OUT_VALID, OUT_WORD, UNDERRUN, IN_READY, IDLE);
    end
    @(negedge SCLK);
    RSTN     = 1'b1;
    IN_DATA  = 8'h55;
    IN_VALID = 1'b1;
    tick();
    IN_VALID = 1'b0;
    checks++;
    if (OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL mid_lat: v=%b want 0", OUT_VALID);
    end
    tick();
    checks++;
    if (OUT_VALID !== 1'b1 || OUT_WORD !== 7'h55) begin
      failures++;
      $display("FAIL mid_word: v=%b w=%h want 1 55",
               OUT_VALID, OUT_WORD);
    end
    tick();
    checks++;
    if (OUT_VALID !== 1'b0) begin
      failures++;
      $display("FAIL mid_tail: v=%b want 0", OUT_VALID);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_flush();
    test_back_to_back();
    test_underrun();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
